// File: rtl/chip_link_rx.sv
// Receive deserializer for one inter-chip port: four-phase valid/ready/parity link words in,
// assembled flits out. Define CHIP_LINK_SYNC_EN to put a 2-flop synchronizer on recv_data_valid.
module chip_link_rx #(
   parameter int FW             = 59,
   parameter int CONNECT        = 2,
   parameter int CHIPDATA_WIDTH = 16,
   localparam int W             = FW + $clog2(CONNECT),
   localparam int N             = (W + CHIPDATA_WIDTH - 1) / CHIPDATA_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHIPDATA_WIDTH-1:0] recv_data_in,
   input  logic                      recv_data_valid,
   input  logic                      recv_data_par,
   output logic                      recv_data_ready,
   output logic                      recv_data_err,
   output logic [W-1:0]              flit_out,
   output logic                      flit_valid,
   input  logic                      flit_ready,
   output logic [7:0]                par_err_cnt
);

   localparam int CW   = CHIPDATA_WIDTH;
   localparam int AW   = N * CW;
   localparam int WCW  = (N > 1) ? $clog2(N) : 1;
   localparam logic [WCW-1:0] LAST = WCW'(N - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, STALL = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [WCW-1:0]  wcnt_q, wcnt_d;
   logic [AW-1:0]   asm_q, asm_d;
   logic [W-1:0]    flit_q, flit_d;
   logic            fv_q, fv_d;
   logic            ready_q, ready_d;
   logic            err_q, err_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            valid_s;
   logic            par_bad_s;
   logic            out_free_s;
   logic [AW+CW-1:0] cat_s;
   logic [AW-1:0]   shifted_s;

`ifdef CHIP_LINK_SYNC_EN
   logic [1:0] sync_q;

   // two-flop synchronizer for the remote chip's request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], recv_data_valid};
      end
   end

   assign valid_s = sync_q[1];
`else
   assign valid_s = recv_data_valid;
`endif

   assign par_bad_s  = (^recv_data_in) != recv_data_par;
   assign out_free_s = !fv_q || flit_ready;
   // first word ends up in the top bits; shifting out of AW drops stale words
   assign cat_s      = {asm_q, recv_data_in};
   assign shifted_s  = cat_s[AW-1:0];

   // handshake FSM, word assembly and output register next-state
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      asm_d   = asm_q;
      flit_d  = flit_q;
      fv_d    = fv_q & ~flit_ready;
      ready_d = ready_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (valid_s) begin
               if (par_bad_s) begin
                  err_d   = 1'b1;
                  ready_d = 1'b1;
                  state_d = ACK;
                  if (cnt_q != 8'hFF) begin
                     cnt_d = cnt_q + 8'd1;
                  end else begin
                     cnt_d = cnt_q;
                  end
               end else if (wcnt_q != LAST) begin
                  asm_d   = shifted_s;
                  wcnt_d  = wcnt_q + WCW'(1);
                  ready_d = 1'b1;
                  state_d = ACK;
               end else if (out_free_s) begin
                  asm_d   = shifted_s;
                  flit_d  = shifted_s[W-1:0];
                  fv_d    = 1'b1;
                  wcnt_d  = '0;
                  ready_d = 1'b1;
                  state_d = ACK;
               end else begin
                  // capture the last word now; the link stays unacknowledged meanwhile
                  asm_d   = shifted_s;
                  state_d = STALL;
               end
            end else begin
               state_d = IDLE;
            end
         end
         STALL: begin
            if (out_free_s) begin
               flit_d  = asm_q[W-1:0];
               fv_d    = 1'b1;
               wcnt_d  = '0;
               ready_d = 1'b1;
               state_d = ACK;
            end else begin
               state_d = STALL;
            end
         end
         ACK: begin
            if (!valid_s) begin
               ready_d = 1'b0;
               err_d   = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = ACK;
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b0;
            err_d   = 1'b0;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         asm_q   <= '0;
         flit_q  <= '0;
         fv_q    <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         asm_q   <= asm_d;
         flit_q  <= flit_d;
         fv_q    <= fv_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign recv_data_ready = ready_q;
   assign recv_data_err   = err_q;
   assign flit_out        = flit_q;
   assign flit_valid      = fv_q;
   assign par_err_cnt     = cnt_q;

endmodule
